// File: rtl/bht_branch_predictor.sv
// rtl/bht_branch_predictor.sv - branch history table of 2-bit saturating counters
//
// Purpose:
//   Supplies the taken/not-taken prediction to fetch and is trained by execute
//   with the resolved branch outcome. It also raises the decode/execute flush
//   on a mispredict and keeps branch and mispredict statistics. After reset, or
//   on a table-flush request, an init sweep writes INIT_STATE into every entry.
//
// Ports:
//   clk                 clock, all state on the rising edge
//   rst                 synchronous active-high reset
//   PCF                 fetch-stage PC used for the lookup
//   Predict_branchF     prediction for PCF (1 = taken), 0 until the table is ready
//   PCE                 execute-stage PC of the branch being resolved
//   StateUpdateEnable   execute holds a branch or jump this cycle
//   PCSrcE              resolved outcome (1 = taken)
//   Prediction_Correct  execute's verdict on the prediction it carried
//   table_flush         one-cycle request to re-initialise the table
//   ready               table initialised and in RUN
//   FlushD / FlushE     flush decode / execute registers on a mispredict
//   branch_count        resolved branches/jumps since reset
//   mispredict_count    mispredicts since reset

module bht_branch_predictor #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        Predict_branchF,
    input  logic [31:0] PCE,
    input  logic        StateUpdateEnable,
    input  logic        PCSrcE,
    input  logic        Prediction_Correct,
    input  logic        table_flush,
    output logic        ready,
    output logic        FlushD,
    output logic        FlushE,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int                    ENTRIES  = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [INDEX_BITS-1:0] r_ptr;
    logic [INDEX_BITS-1:0] w_next_ptr;

    // Counter storage is deliberately not reset; the sweep initialises it.
    logic [1:0]            r_table [ENTRIES];

    logic [31:0]           r_branch_count;
    logic [31:0]           r_mispredict_count;

    logic [INDEX_BITS-1:0] w_lookup_idx;
    logic [INDEX_BITS-1:0] w_update_idx;
    logic [1:0]            w_lookup_entry;
    logic [1:0]            w_update_entry;
    logic [1:0]            w_trained;
    logic                  w_wr_en;
    logic [INDEX_BITS-1:0] w_wr_idx;
    logic [1:0]            w_wr_data;
    logic                  w_mispredict;

    // No tags: the PC bits outside the index are intentionally ignored.
    logic                  w_unused;
    assign w_unused = &{1'b0, PCF[31:INDEX_BITS+2], PCF[1:0],
                              PCE[31:INDEX_BITS+2], PCE[1:0]};

    assign w_lookup_idx   = PCF[INDEX_BITS+1:2];
    assign w_update_idx   = PCE[INDEX_BITS+1:2];
    assign w_lookup_entry = r_table[w_lookup_idx];
    assign w_update_entry = r_table[w_update_idx];

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        if (r_state == S_INIT) begin
            if (table_flush) begin
                w_next_ptr = '0;
            end else begin
                // Pointer wraps to 0 on the last entry, leaving it ready for
                // the next sweep.
                w_next_ptr = r_ptr + INDEX_BITS'(1);
                if (r_ptr == PTR_LAST) begin
                    w_next_state = S_RUN;
                end
            end
        end else begin
            if (table_flush) begin
                w_next_state = S_INIT;
                w_next_ptr   = '0;
            end
        end
    end

    assign ready = (r_state == S_RUN);

    // ------------------------------------------------------------------
    // Table write port: the sweep owns it in INIT, execute training in RUN
    // ------------------------------------------------------------------
    always_comb begin
        w_trained = w_update_entry;
        if (PCSrcE) begin
            if (w_update_entry != 2'b11) begin
                w_trained = w_update_entry + 2'd1;
            end
        end else begin
            if (w_update_entry != 2'b00) begin
                w_trained = w_update_entry - 2'd1;
            end
        end
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = '0;
        w_wr_data = '0;
        if (r_state == S_INIT) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_ptr;
            w_wr_data = INIT_STATE;
        end else if (StateUpdateEnable) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = w_update_idx;
            w_wr_data = w_trained;
        end
    end

    // Reset suppresses any write in flight so a pending update is lost.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_table[w_wr_idx] <= w_wr_data;
        end
    end

    // Lookup reads the pre-update value; there is no write-to-read bypass.
    assign Predict_branchF = ready & w_lookup_entry[1];

    // ------------------------------------------------------------------
    // Mispredict flush and statistics
    // ------------------------------------------------------------------
    assign w_mispredict = StateUpdateEnable & ~Prediction_Correct;
    assign FlushD       = ~rst & w_mispredict;
    assign FlushE       = ~rst & w_mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (StateUpdateEnable) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: doc/bht_branch_predictor.md
Name: bht_branch_predictor

Overview:
- Branch history table (BHT) of 2-bit saturating counters. It supplies the taken/not-taken prediction to fetch and is updated from execute with the resolved branch outcome.
- Owns the pipeline flush request on mispredict and keeps branch/mispredict statistics.
- Contains an init-sweep FSM that writes every entry after reset or on a table-flush request.
- Sits beside the fetch and execute stages. It produces the prediction that travels down the pipeline and is consumed in execute.

Parameters:
- INDEX_BITS, 6, log2 of the entry count (64 entries); index = PC[INDEX_BITS+1:2]
- INIT_STATE, 2'b01, counter value written during the init sweep (weakly not-taken)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- PCF  input  32  fetch-stage PC used for lookup
- Predict_branchF  output  1  prediction for PCF (1 = taken)
- PCE  input  32  execute-stage PC of the instruction being resolved
- StateUpdateEnable  input  1  execute holds a branch or jump this cycle
- PCSrcE  input  1  resolved outcome (1 = taken)
- Prediction_Correct  input  1  execute's verdict on the carried prediction
- table_flush  input  1  one-cycle request to re-initialise the table
- ready  output  1  table initialised and in RUN
- FlushD  output  1  flush decode register on mispredict
- FlushE  output  1  flush execute register on mispredict
- branch_count  output  32  resolved branches/jumps since reset
- mispredict_count  output  32  mispredicts since reset

Behaviour:
- FSM states: INIT, RUN.
  - rst → INIT. Sweep pointer = 0; branch_count = 0; mispredict_count = 0; ready = 0.
- INIT:
  - Each cycle writes INIT_STATE to entry[ptr], then ptr++.
  - After writing entry 2^INDEX_BITS−1, the next state is RUN. The sweep takes exactly 2^INDEX_BITS cycles (64 by default).
  - ready rises on the first RUN cycle.
- RUN:
  - ready = 1.
  - table_flush = 1 → INIT with ptr = 0 on the next edge. Statistics are not cleared.
  - table_flush during INIT restarts the sweep at ptr = 0.
- Lookup:
  - Combinational: Predict_branchF = entry[PCF index][1] when ready, otherwise 0.
  - Entry contents are undefined before the sweep, so the prediction is forced to 0 during INIT.
- Update:
  - Applies in RUN only, when StateUpdateEnable = 1, to entry[PCE index].
  - PCSrcE = 1: counter increments, saturating at 3.
  - PCSrcE = 0: counter decrements, saturating at 0.
  - Updates arriving during INIT are dropped. The sweep owns the write port.
- Read/write same index in one cycle: the lookup returns the pre-update value. There is no bypass.
- Rest of the PC is ignored: no tags, so aliasing between PCs sharing index bits is accepted.
- Flush:
  - FlushD = FlushE = StateUpdateEnable & ~Prediction_Correct.
  - Combinational and zero latency, so the redirect and flush take effect on the same edge.
  - Active in INIT as well: correctness of already-fetched instructions does not depend on table state.
  - Both are 0 whenever rst = 1.
- Statistics:
  - branch_count increments on every cycle with StateUpdateEnable = 1.
  - mispredict_count increments when additionally Prediction_Correct = 0.
  - Both count in INIT and RUN, and wrap modulo 2^32.
- Reset mid-sweep or mid-update: rst dominates everything. The FSM returns to INIT with ptr = 0 and counters at 0. The pending update is lost.
- Reset output values: Predict_branchF = 0, ready = 0, FlushD = 0, FlushE = 0, branch_count = 0, mispredict_count = 0.

Test Plan:
- Init sweep: rst for 1 cycle, then release.
  - ready = 0 for exactly 64 cycles and 1 on cycle 65.
  - Lookup of any PC (e.g. 0x0000_0100) gives Predict_branchF = 0, since INIT_STATE = 01.
- Saturation up: in RUN, PCE = 0x40 with PCSrcE = 1 for 4 consecutive updates.
  - Entry goes 01→10→11→11.
  - Predict_branchF for PCF = 0x40 becomes 1 after the first update.
  - A single not-taken update → 10, prediction still 1.
- Saturation down and aliasing: PCE = 0x40 with PCSrcE = 0 ×3 → 00, prediction 0.
  - PCF = 0x140 aliases to index 16 and also predicts 0.
- Mispredict flush and stats: StateUpdateEnable = 1, Prediction_Correct = 0.
  - FlushD = FlushE = 1 in the same cycle.
  - mispredict_count goes 0→1 and branch_count 0→1 on the next edge.
  - A following correct branch increments branch_count only.
- Same-index read/write: PCF = PCE = 0x80, entry = 01, PCSrcE = 1.
  - Predict_branchF = 0 this cycle and 1 next cycle.
- Flush/reset mid-operation:
  - table_flush in RUN: ready = 0 next cycle for 64 cycles, and an update issued during that window is ignored (entry reads 01 after the sweep). Statistics are retained.
  - rst asserted at sweep cycle 30: ptr restarts, and the full 64-cycle sweep follows.
